// File: rtl/prog_delay_line_if.sv
// Handshake/config bundle for prog_delay_line.
// i_en exists only when PROG_DELAY_STALL_EN is defined.
interface prog_delay_line_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH_W = 5
);
  logic [WIDTH-1:0]   i_data;
  logic               i_cfg_we;
  logic [DEPTH_W-1:0] i_cfg_depth;
`ifdef PROG_DELAY_STALL_EN
  logic               i_en;
`endif
  logic [WIDTH-1:0]   o_data;
  logic               o_valid;
  logic [DEPTH_W-1:0] o_depth;

  modport master (
    output i_data, i_cfg_we, i_cfg_depth,
`ifdef PROG_DELAY_STALL_EN
    output i_en,
`endif
    input  o_data, o_valid, o_depth
  );

  modport slave (
    input  i_data, i_cfg_we, i_cfg_depth,
`ifdef PROG_DELAY_STALL_EN
    input  i_en,
`endif
    output o_data, o_valid, o_depth
  );
endinterface

// File: rtl/prog_delay_line.sv
// Run-time programmable delay line built on a MAX_DEPTH-entry ring buffer.
// Optional advance enable (i_en) is compiled in with PROG_DELAY_STALL_EN.
module prog_delay_line #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned MAX_DEPTH     = 16,
  parameter int unsigned DEFAULT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  prog_delay_line_if.slave  bus
);
  localparam int unsigned AW = $clog2(MAX_DEPTH);
  localparam int unsigned DW = AW + 1;

  logic [WIDTH-1:0] mem_q [MAX_DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [DW-1:0]    fc_q, fc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [DW-1:0]    cfg_clamped;
  logic             valid_q, valid_d;
  logic             adv;
  logic [AW-1:0]    rd_idx;
  int unsigned      rd_int;

  always_comb begin
`ifdef PROG_DELAY_STALL_EN
    adv = ~rst & bus.i_en;
`else
    adv = ~rst;
`endif
  end

  always_comb begin
    if (bus.i_cfg_depth == '0)
      cfg_clamped = DW'(1);
    else if (bus.i_cfg_depth > DW'(MAX_DEPTH))
      cfg_clamped = DW'(MAX_DEPTH);
    else
      cfg_clamped = bus.i_cfg_depth;
  end

  // Combinational read of the current contents gives read-before-write at
  // depth == MAX_DEPTH, where the read slot equals the slot being written.
  always_comb begin
    rd_int = 32'(wp_q) + MAX_DEPTH - 32'(depth_q);
    if (rd_int >= MAX_DEPTH)
      rd_int = rd_int - MAX_DEPTH;
    rd_idx = AW'(rd_int);
  end

  always_comb begin
    wp_d    = wp_q;
    fc_d    = fc_q;
    depth_d = depth_q;
    if (adv)
      wp_d = (wp_q == AW'(MAX_DEPTH - 1)) ? '0 : wp_q + AW'(1);
    // A reconfiguring cycle that also advances supplies the first new sample.
    if (bus.i_cfg_we) begin
      depth_d = cfg_clamped;
      fc_d    = adv ? DW'(1) : '0;
    end else if (adv && (fc_q < depth_q)) begin
      fc_d = fc_q + DW'(1);
    end
    valid_d = (fc_d == depth_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      fc_q    <= '0;
      depth_q <= DW'(DEFAULT_DEPTH);
      valid_q <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      fc_q    <= fc_d;
      depth_q <= depth_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv)
      mem_q[wp_q] <= bus.i_data;
  end

  assign bus.o_data  = valid_q ? mem_q[rd_idx] : '0;
  assign bus.o_valid = valid_q;
  assign bus.o_depth = depth_q;
endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line (WIDTH=8, MAX_DEPTH=16, DEFAULT_DEPTH=2).
module tb_prog_delay_line;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prog_delay_line_if #(.WIDTH(8), .DEPTH_W(5)) bus ();

  prog_delay_line #(
    .WIDTH(8),
    .MAX_DEPTH(16),
    .DEFAULT_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_v, input int exp_d);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'(exp_v));
    chk({tag, "_data"},  32'(bus.o_data),  32'(exp_d));
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_data      = '0;
    bus.i_cfg_we    = 1'b0;
    bus.i_cfg_depth = '0;
`ifdef PROG_DELAY_STALL_EN
    bus.i_en        = 1'b1;
`endif
    #1;

    // reset held two cycles
    step();
    step();
    chk_out("reset", 1'b0, 0);
    chk("reset_depth", 32'(bus.o_depth), 32'd2);

    // stream 1,2,3.. at default depth 2
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus.i_data = 8'(k);
      step();
      if (k < 2) chk_out("stream", 1'b0, 0);
      else       chk_out("stream", 1'b1, k - 1);
    end

    // reconfigure to depth 5 while streaming 0x10..
    for (int j = 0; j < 10; j++) begin
      bus.i_data      = 8'(16 + j);
      bus.i_cfg_we    = (j == 0);
      bus.i_cfg_depth = 5'd5;
      step();
      bus.i_cfg_we = 1'b0;
      if (j == 0) chk("recfg_depth", 32'(bus.o_depth), 32'd5);
      if (j + 1 < 5) chk_out("recfg", 1'b0, 0);
      else           chk_out("recfg", 1'b1, 16 + j + 1 - 5);
    end

    // clamp 0 -> 1
    for (int j = 0; j < 5; j++) begin
      bus.i_data      = 8'(32 + j);
      bus.i_cfg_we    = (j == 0);
      bus.i_cfg_depth = 5'd0;
      step();
      bus.i_cfg_we = 1'b0;
      if (j == 0) chk("clamp0_depth", 32'(bus.o_depth), 32'd1);
      chk_out("clamp0", 1'b1, 32 + j);
    end

    // clamp 31 -> 16, run long enough for several pointer wraps
    for (int j = 0; j < 60; j++) begin
      bus.i_data      = 8'(64 + j);
      bus.i_cfg_we    = (j == 0);
      bus.i_cfg_depth = 5'd31;
      step();
      bus.i_cfg_we = 1'b0;
      if (j == 0) chk("clamp31_depth", 32'(bus.o_depth), 32'd16);
      if (j + 1 < 16) chk_out("clamp31", 1'b0, 0);
      else            chk_out("clamp31", 1'b1, 64 + j + 1 - 16);
    end

    // rst together with cfg load: reset wins
    rst             = 1'b1;
    bus.i_cfg_we    = 1'b1;
    bus.i_cfg_depth = 5'd7;
    step();
    bus.i_cfg_we = 1'b0;
    chk("conflict_depth", 32'(bus.o_depth), 32'd2);
    chk_out("conflict", 1'b0, 0);
    rst = 1'b0;

    // depth 4 stream, 0xAA in flight when rst hits
    for (int j = 0; j < 6; j++) begin
      bus.i_data      = 8'(80 + j);
      bus.i_cfg_we    = (j == 0);
      bus.i_cfg_depth = 5'd4;
      step();
      bus.i_cfg_we = 1'b0;
      if (j + 1 < 4) chk_out("d4", 1'b0, 0);
      else           chk_out("d4", 1'b1, 80 + j + 1 - 4);
    end
    bus.i_data = 8'hAA;
    step();
    chk_out("d4_pre_rst", 1'b1, 83);
    rst        = 1'b1;
    bus.i_data = 8'hAB;
    step();
    chk_out("midrst", 1'b0, 0);
    chk("midrst_depth", 32'(bus.o_depth), 32'd2);
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      bus.i_data      = 8'(96 + j);
      bus.i_cfg_we    = (j == 0);
      bus.i_cfg_depth = 5'd4;
      step();
      bus.i_cfg_we = 1'b0;
      if (j + 1 < 4) chk_out("refill", 1'b0, 0);
      else           chk_out("refill", 1'b1, 96 + j + 1 - 4);
    end

`ifdef PROG_DELAY_STALL_EN
    begin
      logic en_pat [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      int   nadv = 0;
      for (int j = 0; j < 11; j++) begin
        bus.i_en        = en_pat[j];
        bus.i_data      = en_pat[j] ? 8'(nadv + 1) : 8'hFF;
        bus.i_cfg_we    = (j == 0);
        bus.i_cfg_depth = 5'd3;
        step();
        bus.i_cfg_we = 1'b0;
        if (en_pat[j]) nadv++;
        if (j == 0) chk("stall_depth", 32'(bus.o_depth), 32'd3);
        if (nadv < 3) chk_out("stall", 1'b0, 0);
        else          chk_out("stall", 1'b1, nadv - 2);
      end
      bus.i_en = 1'b1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
